parking_gate_ctrl: RTL

- Entry/exit barrier controller directly upstream of the parking occupancy counter.
- Debounces the raw entry and exit loop sensors and decides admission from the counter's space flags.
- Drives both barriers and emits single-cycle car_entered/car_exited events, with a class flag, that the counter consumes.
- Guarantees the counter never sees an entry and an exit event in the same cycle.

---
 rtl/parking_pkg.sv | 35 +++
 rtl/parking_sensor_debounce.sv | 38 +++
 rtl/parking_gate_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
// Timer widths and default timing parameters live here.
package parking_pkg;

  localparam int TIMER_W    = 16;
  localparam int DEBOUNCE_W = 8;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_OPEN_TIMEOUT    = 1000;
  localparam int DEF_CLOSE_DELAY     = 50;

  typedef enum logic [2:0] {
    E_IDLE   = 3'd0,
    E_CHECK  = 3'd1,
    E_REJECT = 3'd2,
    E_OPEN   = 3'd3,
    E_CLOSE  = 3'd4
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_OPEN  = 2'd1,
    X_CLOSE = 2'd2
  } exit_state_t;

  // Saturating increment so a timer parks at all-ones instead of wrapping.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    if (v == {TIMER_W{1'b1}}) begin
      return v;
    end else begin
      return v + TIMER_W'(1);
    end
  endfunction

endpackage

// File: rtl/parking_sensor_debounce.sv
// Loop-sensor debouncer: the output level follows the raw input only after
// the raw value has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module parking_sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic sensor_level
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [DEBOUNCE_W-1:0] cnt_r;
  logic                  level_r;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sensor_raw != level_r) begin
      if (cnt_r >= CNT_LAST) begin
        level_r <= sensor_raw;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + DEBOUNCE_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign sensor_level = level_r;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding the occupancy counter: two lane FSMs
// plus an event arbiter that never lets entry and exit events coincide.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int CLOSE_DELAY     = DEF_CLOSE_DELAY
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_sensor_raw,
  input  logic entry_is_uni,
  input  logic exit_sensor_raw,
  input  logic exit_is_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_reject,
  output logic entry_timeout
);

  localparam logic [TIMER_W-1:0] OPEN_LAST  = TIMER_W'(OPEN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] CLOSE_LAST = TIMER_W'(CLOSE_DELAY - 1);

  logic               entry_level_s;
  logic               exit_level_s;
  logic               entry_pass_s;
  logic               exit_pass_s;
  logic               entry_space_s;
  entry_state_t       e_state_r;
  exit_state_t        x_state_r;
  logic [TIMER_W-1:0] e_timer_r;
  logic [TIMER_W-1:0] x_timer_r;
  logic               e_uni_r;
  logic               x_uni_r;
  logic               exit_pending_r;
  logic               pending_uni_r;

  parking_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
    .clk          (clk),
    .reset        (reset),
    .sensor_raw   (entry_sensor_raw),
    .sensor_level (entry_level_s)
  );

  parking_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clk          (clk),
    .reset        (reset),
    .sensor_raw   (exit_sensor_raw),
    .sensor_level (exit_level_s)
  );

  // Passage = debounced sensor low while the barrier is open.
  always_comb begin
    entry_pass_s  = 1'b0;
    exit_pass_s   = 1'b0;
    entry_space_s = 1'b0;
    if ((e_state_r == E_OPEN) && !entry_level_s) begin
      entry_pass_s = 1'b1;
    end else begin
      entry_pass_s = 1'b0;
    end
    if ((x_state_r == X_OPEN) && !exit_level_s) begin
      exit_pass_s = 1'b1;
    end else begin
      exit_pass_s = 1'b0;
    end
    if (entry_is_uni) begin
      entry_space_s = uni_is_vacated_space;
    end else begin
      entry_space_s = is_vacated_space;
    end
  end

  // Entry lane FSM; passage is checked before timeout so a late car still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_state_r       <= E_IDLE;
      e_timer_r       <= '0;
      e_uni_r         <= 1'b0;
      entry_gate_open <= 1'b0;
      entry_reject    <= 1'b0;
      entry_timeout   <= 1'b0;
    end else begin
      entry_timeout <= 1'b0;
      case (e_state_r)
        E_IDLE: begin
          if (entry_level_s) begin
            e_state_r <= E_CHECK;
          end
        end
        E_CHECK: begin
          e_uni_r   <= entry_is_uni;
          e_timer_r <= '0;
          if (entry_space_s) begin
            e_state_r       <= E_OPEN;
            entry_gate_open <= 1'b1;
          end else begin
            e_state_r    <= E_REJECT;
            entry_reject <= 1'b1;
          end
        end
        E_REJECT: begin
          if (!entry_level_s) begin
            e_state_r    <= E_IDLE;
            entry_reject <= 1'b0;
          end
        end
        E_OPEN: begin
          if (!entry_level_s) begin
            e_state_r       <= E_CLOSE;
            e_timer_r       <= '0;
            entry_gate_open <= 1'b0;
          end else if (e_timer_r >= OPEN_LAST) begin
            e_state_r       <= E_CLOSE;
            e_timer_r       <= '0;
            entry_gate_open <= 1'b0;
            entry_timeout   <= 1'b1;
          end else begin
            e_timer_r <= sat_inc(e_timer_r);
          end
        end
        E_CLOSE: begin
          if (e_timer_r >= CLOSE_LAST) begin
            e_state_r <= E_IDLE;
            e_timer_r <= '0;
          end else begin
            e_timer_r <= sat_inc(e_timer_r);
          end
        end
        default: begin
          e_state_r       <= E_IDLE;
          e_timer_r       <= '0;
          entry_gate_open <= 1'b0;
          entry_reject    <= 1'b0;
        end
      endcase
    end
  end

  // Exit lane FSM: no space check and a silent timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_state_r      <= X_IDLE;
      x_timer_r      <= '0;
      x_uni_r        <= 1'b0;
      exit_gate_open <= 1'b0;
    end else begin
      case (x_state_r)
        X_IDLE: begin
          if (exit_level_s) begin
            x_state_r      <= X_OPEN;
            x_uni_r        <= exit_is_uni;
            x_timer_r      <= '0;
            exit_gate_open <= 1'b1;
          end
        end
        X_OPEN: begin
          if (!exit_level_s || (x_timer_r >= OPEN_LAST)) begin
            x_state_r      <= X_CLOSE;
            x_timer_r      <= '0;
            exit_gate_open <= 1'b0;
          end else begin
            x_timer_r <= sat_inc(x_timer_r);
          end
        end
        X_CLOSE: begin
          if (x_timer_r >= CLOSE_LAST) begin
            x_state_r <= X_IDLE;
            x_timer_r <= '0;
          end else begin
            x_timer_r <= sat_inc(x_timer_r);
          end
        end
        default: begin
          x_state_r      <= X_IDLE;
          x_timer_r      <= '0;
          exit_gate_open <= 1'b0;
        end
      endcase
    end
  end

  // Event arbiter: entry wins a collision, the exit event waits one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      exit_pending_r     <= 1'b0;
      pending_uni_r      <= 1'b0;
    end else begin
      car_entered        <= entry_pass_s;
      is_uni_car_entered <= entry_pass_s & e_uni_r;
      if (entry_pass_s) begin
        car_exited        <= 1'b0;
        is_uni_car_exited <= 1'b0;
        exit_pending_r    <= exit_pending_r | exit_pass_s;
        if (exit_pending_r) begin
          pending_uni_r <= pending_uni_r;
        end else begin
          pending_uni_r <= x_uni_r;
        end
      end else if (exit_pending_r) begin
        car_exited        <= 1'b1;
        is_uni_car_exited <= pending_uni_r;
        exit_pending_r    <= 1'b0;
        pending_uni_r     <= 1'b0;
      end else begin
        car_exited        <= exit_pass_s;
        is_uni_car_exited <= exit_pass_s & x_uni_r;
        exit_pending_r    <= 1'b0;
        pending_uni_r     <= 1'b0;
      end
    end
  end

endmodule
